// File: rtl/rr_arb_pkg.sv
// Shared types and defaults for the round-robin register arbiter.
// Holds the FSM state enum and pointer wrap helper.
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int DEF_N        = 4;
  localparam int DEF_W        = 8;
  localparam int DEF_MAX_HOLD = 4;

  // Pointer to the requester after owner, wrapping at n.
  function automatic int next_ptr(input int owner, input int n);
    return (owner + 1 >= n) ? 0 : owner + 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority encoder: first request at or after ptr.
// Doubles the request vector so the wrap needs no special case.
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic           found;

  // Mask the low copy below ptr, then find the first set bit.
  always_comb begin
    dbl   = {req, req};
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (k < int'(ptr)) dbl[k] = 1'b0;
    end
    for (int k = 0; k < 2 * N; k++) begin
      if (!found && dbl[k]) begin
        found = 1'b1;
        idx   = IW'(k % N);
      end
    end
    any = found;
    if (found) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter sharing one W-bit register among N requesters.
// Each capture pulses q_valid once and records the owner ID.
module rr_reg_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int N        = DEF_N,
  parameter  int W        = DEF_W,
  parameter  int MAX_HOLD = DEF_MAX_HOLD,
  localparam int IW       = $clog2(N),
  localparam int HW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   req_valid,
  input  logic [N-1:0]   req_lock,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic [W-1:0]   q_data,
  output logic           q_valid,
  output logic [IW-1:0]  q_owner
);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [W-1:0]  q_data_q, q_data_d;
  logic          q_valid_q, q_valid_d;
  logic [IW-1:0] q_owner_q, q_owner_d;

  logic [N-1:0]  pick_gnt;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic [W-1:0]  own_data;
  logic          hold_ok;

  rr_priority_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign own_data  = req_data[int'(owner_q) * W +: W];
  assign hold_ok   = 32'(hold_q) < 32'(MAX_HOLD - 1);
  assign req_ready = gnt_q;
  assign q_data    = q_data_q;
  assign q_valid   = q_valid_q;
  assign q_owner   = q_owner_q;

  // Next-state, grant, hold and capture logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    hold_d    = hold_q;
    q_data_d  = q_data_q;
    q_valid_d = 1'b0;
    q_owner_d = q_owner_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_gnt;
          owner_d = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (req_valid[owner_q]) begin
          q_data_d  = own_data;
          q_owner_d = owner_q;
          q_valid_d = 1'b1;
        end
        if (req_valid[owner_q] && req_lock[owner_q] && hold_ok) begin
          hold_d = hold_q + HW'(1);
        end else begin
          ptr_d   = IW'(next_ptr(int'(owner_q), N));
          hold_d  = '0;
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and shared data register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      owner_q   <= '0;
      hold_q    <= '0;
      q_data_q  <= '0;
      q_valid_q <= 1'b0;
      q_owner_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      hold_q    <= hold_d;
      q_data_q  <= q_data_d;
      q_valid_q <= q_valid_d;
      q_owner_q <= q_owner_d;
    end
  end

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Bench for rr_reg_arbiter: N=4 scoreboard checks plus an N=3 copy.
// Expected captures are queued at stimulus time, popped on q_valid.
module tb_rr_reg_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_lock = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   q_data;
  logic           q_valid;
  logic [1:0]     q_owner;

  logic [2:0]  v3 = '0;
  logic [2:0]  l3 = '0;
  logic [23:0] d3 = '0;
  logic [2:0]  r3;
  logic [7:0]  qd3;
  logic        qv3;
  logic [1:0]  qo3;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] owner;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  rr_reg_arbiter #(.N(4), .W(8), .MAX_HOLD(4)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .req_data  (req_data),
    .req_ready (req_ready),
    .q_data    (q_data),
    .q_valid   (q_valid),
    .q_owner   (q_owner)
  );

  rr_reg_arbiter #(.N(3), .W(8), .MAX_HOLD(4)) u_dut3 (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (v3),
    .req_lock  (l3),
    .req_data  (d3),
    .req_ready (r3),
    .q_data    (qd3),
    .q_valid   (qv3),
    .q_owner   (qo3)
  );

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && q_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: owner=%0d data=%h, none queued",
                 q_owner, q_data);
      end else begin
        e = sb.pop_front();
        if ({q_owner, q_data} !== {e.owner, e.data}) begin
          errors++;
          $display("FAIL sb_capture: got owner=%0d data=%h, exp owner=%0d data=%h",
                   q_owner, q_data, e.owner, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    req_lock  = '0;
    req_data  = '0;
    v3 = '0;
    l3 = '0;
    d3 = '0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({q_valid, req_ready, q_data, q_owner} !== '0) begin
      errors++;
      $display("FAIL reset_out: qv=%b rdy=%b qd=%h qo=%0d, exp all 0",
               q_valid, req_ready, q_data, q_owner);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if ({q_valid, req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_idle: qv=%b rdy=%b, exp 0", q_valid, req_ready);
    end
  endtask

  task automatic test_single();
    apply_reset();
    req_valid = 4'b0100;
    req_data[16 +: 8] = 8'hA5;
    sb.push_back(exp_t'{2'd2, 8'hA5});
    tick();
    checks++;
    if (req_ready !== 4'b0100 || q_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: rdy=%b qv=%b, exp 0100 0", req_ready, q_valid);
    end
    tick();
    checks++;
    if (q_valid !== 1'b1 || q_data !== 8'hA5 || q_owner !== 2'd2 ||
        req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL single_cap: qv=%b qd=%h qo=%0d rdy=%b, exp 1 a5 2 0000",
               q_valid, q_data, q_owner, req_ready);
    end
    req_valid = '0;
    tick();
    checks++;
    if (q_valid !== 1'b0 || q_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_hold: qv=%b qd=%h, exp 0 a5", q_valid, q_data);
    end
  endtask

  task automatic test_rotation();
    apply_reset();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'h10 + 8'(i);
    req_valid = 4'b1111;
    sb.push_back(exp_t'{2'd0, 8'h10});
    sb.push_back(exp_t'{2'd1, 8'h11});
    sb.push_back(exp_t'{2'd2, 8'h12});
    sb.push_back(exp_t'{2'd3, 8'h13});
    sb.push_back(exp_t'{2'd0, 8'h10});
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (q_valid !== ((k % 2) == 0)) begin
        errors++;
        $display("FAIL rot_pulse[%0d]: qv=%b, exp %b", k, q_valid, (k % 2) == 0);
      end
    end
    req_valid = '0;
    tick();
    checks++;
    if (q_valid !== 1'b0) begin
      errors++;
      $display("FAIL rot_end: qv=%b, exp 0", q_valid);
    end
  endtask

  task automatic test_lock();
    logic [6:0]      exp_qv;
    logic [6:0][3:0] exp_rdy;
    exp_qv  = 7'b1011110;
    exp_rdy = {4'b0000, 4'b0100, 4'b0000, 4'b0010,
               4'b0010, 4'b0010, 4'b0010};
    apply_reset();
    req_valid = 4'b0110;
    req_lock  = 4'b0010;
    req_data[8 +: 8]  = 8'h71;
    req_data[16 +: 8] = 8'h82;
    for (int i = 0; i < 4; i++) sb.push_back(exp_t'{2'd1, 8'h71});
    sb.push_back(exp_t'{2'd2, 8'h82});
    for (int k = 0; k < 7; k++) begin
      tick();
      checks++;
      if (q_valid !== exp_qv[k] || req_ready !== exp_rdy[k]) begin
        errors++;
        $display("FAIL lock_seq[%0d]: qv=%b rdy=%b, exp %b %b",
                 k + 1, q_valid, req_ready, exp_qv[k], exp_rdy[k]);
      end
    end
    req_valid = '0;
    req_lock  = '0;
    tick();
    checks++;
    if (q_valid !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL lock_end: qv=%b rdy=%b, exp 0 0000", q_valid, req_ready);
    end
  endtask

  task automatic test_withdraw();
    apply_reset();
    req_valid = 4'b1000;
    req_data[24 +: 8] = 8'hC3;
    tick();
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL wd_grant: rdy=%b, exp 1000", req_ready);
    end
    req_valid = 4'b0000;
    tick();
    checks++;
    if (q_valid !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL wd_nocap: qv=%b rdy=%b, exp 0 0000", q_valid, req_ready);
    end
    req_valid = 4'b1001;
    req_data[0 +: 8] = 8'h0D;
    sb.push_back(exp_t'{2'd0, 8'h0D});
    tick();
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL wd_regrant: rdy=%b, exp 0001", req_ready);
    end
    req_valid = 4'b0001;
    tick();
    checks++;
    if (q_valid !== 1'b1 || q_owner !== 2'd0 || q_data !== 8'h0D) begin
      errors++;
      $display("FAIL wd_cap: qv=%b qo=%0d qd=%h, exp 1 0 0d",
               q_valid, q_owner, q_data);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req_valid = 4'b0010;
    req_lock  = 4'b0010;
    req_data[8 +: 8] = 8'h3C;
    tick();
    tick();
    checks++;
    if (q_valid !== 1'b1 || q_data !== 8'h3C || q_owner !== 2'd1 ||
        req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL rmid_pre: qv=%b qd=%h qo=%0d rdy=%b, exp 1 3c 1 0010",
               q_valid, q_data, q_owner, req_ready);
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({q_valid, req_ready, q_data, q_owner} !== '0) begin
      errors++;
      $display("FAIL rmid_async: qv=%b rdy=%b qd=%h qo=%0d, exp all 0",
               q_valid, req_ready, q_data, q_owner);
    end
    req_lock  = '0;
    req_valid = '0;
    tick();
    reset_n   = 1'b1;
    req_valid = 4'b0011;
    tick();
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rmid_ptr0: rdy=%b, exp 0001", req_ready);
    end
    req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_wrap3();
    apply_reset();
    v3 = 3'b010;
    d3[8 +: 8] = 8'h5A;
    tick();
    checks++;
    if (r3 !== 3'b010) begin
      errors++;
      $display("FAIL w3_g1: rdy=%b, exp 010", r3);
    end
    tick();
    checks++;
    if (qv3 !== 1'b1 || qo3 !== 2'd1 || qd3 !== 8'h5A) begin
      errors++;
      $display("FAIL w3_c1: qv=%b qo=%0d qd=%h, exp 1 1 5a", qv3, qo3, qd3);
    end
    v3 = 3'b011;
    d3[0 +: 8] = 8'h11;
    tick();
    checks++;
    if (r3 !== 3'b001) begin
      errors++;
      $display("FAIL w3_g0: rdy=%b, exp 001", r3);
    end
    tick();
    checks++;
    if (qv3 !== 1'b1 || qo3 !== 2'd0 || qd3 !== 8'h11) begin
      errors++;
      $display("FAIL w3_c0: qv=%b qo=%0d qd=%h, exp 1 0 11", qv3, qo3, qd3);
    end
    tick();
    checks++;
    if (r3 !== 3'b010) begin
      errors++;
      $display("FAIL w3_g1b: rdy=%b, exp 010", r3);
    end
    tick();
    v3 = 3'b101;
    d3[16 +: 8] = 8'hE2;
    tick();
    checks++;
    if (r3 !== 3'b100) begin
      errors++;
      $display("FAIL w3_g2: rdy=%b, exp 100", r3);
    end
    tick();
    checks++;
    if (qv3 !== 1'b1 || qo3 !== 2'd2 || qd3 !== 8'hE2) begin
      errors++;
      $display("FAIL w3_c2: qv=%b qo=%0d qd=%h, exp 1 2 e2", qv3, qo3, qd3);
    end
    tick();
    checks++;
    if (r3 !== 3'b001) begin
      errors++;
      $display("FAIL w3_wrap0: rdy=%b, exp 001", r3);
    end
    v3 = '0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_lock();
    test_withdraw();
    test_reset_mid();
    test_wrap3();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d captures still queued, exp 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
